// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback datapath for the RV32I pipeline.
// Latency: MEM inputs captured on posedge clk_i appear on rd_* in the following cycle.
// Backpressure: stall_i holds every WB field and the retire counter; flush_i loads a bubble and overrides stall_i.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   stall_i, flush_i      pipeline hold / kill of the incoming MEM instruction
//   mem_*_i               MEM-stage results (valid, rd write enable/address, wb select,
//                         ALU result / load address, PC, U-immediate, raw load word, funct3)
//   rd_wren_o/addr_o/data_o  regfile write port (address and data forced to 0 when not writing)
//   wb_valid_o            WB holds a real instruction
//   instret_o             retired-instruction counter
// Optional macro WB_STAGE_BYPASS_EN adds rs1/rs2 WB->ID bypass muxes
// (rs1_addr_i, rs2_addr_i, rs1_raw_i, rs2_raw_i, rs1_byp_o, rs2_byp_o).

module wb_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  mem_valid_i,
  input  logic                  mem_rd_wren_i,
  input  logic [ADDR_WIDTH-1:0] mem_rd_addr_i,
  input  logic [1:0]            mem_wb_sel_i,
  input  logic [DATA_WIDTH-1:0] mem_alu_data_i,
  input  logic [DATA_WIDTH-1:0] mem_pc_i,
  input  logic [DATA_WIDTH-1:0] mem_imm_i,
  input  logic [DATA_WIDTH-1:0] mem_ld_data_i,
  input  logic [2:0]            mem_funct3_i,
`ifdef WB_STAGE_BYPASS_EN
  input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic [DATA_WIDTH-1:0] rs1_raw_i,
  input  logic [DATA_WIDTH-1:0] rs2_raw_i,
  output logic [DATA_WIDTH-1:0] rs1_byp_o,
  output logic [DATA_WIDTH-1:0] rs2_byp_o,
`endif
  output logic                  rd_wren_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  wb_valid_o,
  output logic [CNT_WIDTH-1:0]  instret_o
);

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_PC4  = 2'd2;

  logic                  valid;
  logic                  wren;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [1:0]            wb_sel;
  logic [DATA_WIDTH-1:0] alu_data;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] imm;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [2:0]            funct3;
  logic [CNT_WIDTH-1:0]  instret;

  // Only valid is cleared on flush; the payload fields are don't-care
  // behind a bubble, so they simply hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid    <= 1'b0;
      wren     <= 1'b0;
      rd_addr  <= '0;
      wb_sel   <= '0;
      alu_data <= '0;
      pc       <= '0;
      imm      <= '0;
      ld_data  <= '0;
      funct3   <= '0;
    end else if (flush_i) begin
      valid    <= 1'b0;
    end else if (!stall_i) begin
      valid    <= mem_valid_i;
      wren     <= mem_rd_wren_i;
      rd_addr  <= mem_rd_addr_i;
      wb_sel   <= mem_wb_sel_i;
      alu_data <= mem_alu_data_i;
      pc       <= mem_pc_i;
      imm      <= mem_imm_i;
      ld_data  <= mem_ld_data_i;
      funct3   <= mem_funct3_i;
    end
  end

  // The instruction sitting in WB retires on the edge it leaves the stage,
  // whether or not the incoming one is flushed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instret <= '0;
    end else if (valid && !stall_i) begin
      instret <= instret + CNT_WIDTH'(1);
    end
  end

  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_ext;

  always_comb begin
    ld_byte = 8'h00;
    case (alu_data[1:0])
      2'd0: ld_byte = ld_data[7:0];
      2'd1: ld_byte = ld_data[15:8];
      2'd2: ld_byte = ld_data[23:16];
      default: ld_byte = ld_data[31:24];
    endcase
    // Misaligned halfword offsets are not trapped here; bit 0 is ignored.
    ld_half = alu_data[1] ? ld_data[31:16] : ld_data[15:0];

    ld_ext = ld_data;
    case (funct3)
      3'b000: ld_ext = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b100: ld_ext = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      3'b001: ld_ext = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      3'b101: ld_ext = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      default: ld_ext = ld_data;
    endcase
  end

  logic [DATA_WIDTH-1:0] wb_data;

  always_comb begin
    wb_data = imm;
    case (wb_sel)
      SEL_ALU:  wb_data = alu_data;
      SEL_LOAD: wb_data = ld_ext;
      SEL_PC4:  wb_data = pc + DATA_WIDTH'(4);
      default:  wb_data = imm;
    endcase
  end

  logic write;
  assign write = valid && wren && (rd_addr != '0);

  assign rd_wren_o  = write;
  assign rd_addr_o  = write ? rd_addr : '0;
  assign rd_data_o  = write ? wb_data : '0;
  assign wb_valid_o = valid;
  assign instret_o  = instret;

`ifdef WB_STAGE_BYPASS_EN
  // x0 can never match because rd_wren_o is already low for it.
  assign rs1_byp_o = (write && (rd_addr == rs1_addr_i)) ? wb_data : rs1_raw_i;
  assign rs2_byp_o = (write && (rd_addr == rs2_addr_i)) ? wb_data : rs2_raw_i;
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, valid, wren;
  logic [4:0]  rd;
  logic [1:0]  sel;
  logic [31:0] alu, pc, imm, ld;
  logic [2:0]  f3;

  logic        rd_wren, wb_valid, rd_wren_s, wb_valid_s;
  logic [4:0]  rd_addr, rd_addr_s;
  logic [31:0] rd_data, rd_data_s, instret;
  logic [2:0]  instret_s;

`ifdef WB_STAGE_BYPASS_EN
  logic [4:0]  rs1_a, rs2_a;
  logic [31:0] rs1_raw, rs2_raw, rs1_byp, rs2_byp, rs1_byp_s, rs2_byp_s;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_stage u_dut (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .flush_i(flush),
    .mem_valid_i(valid), .mem_rd_wren_i(wren), .mem_rd_addr_i(rd),
    .mem_wb_sel_i(sel), .mem_alu_data_i(alu), .mem_pc_i(pc),
    .mem_imm_i(imm), .mem_ld_data_i(ld), .mem_funct3_i(f3),
`ifdef WB_STAGE_BYPASS_EN
    .rs1_addr_i(rs1_a), .rs2_addr_i(rs2_a), .rs1_raw_i(rs1_raw), .rs2_raw_i(rs2_raw),
    .rs1_byp_o(rs1_byp), .rs2_byp_o(rs2_byp),
`endif
    .rd_wren_o(rd_wren), .rd_addr_o(rd_addr), .rd_data_o(rd_data),
    .wb_valid_o(wb_valid), .instret_o(instret)
  );

  // Narrow-counter instance so the wrap-around is reachable in a short run.
  wb_stage #(.CNT_WIDTH(3)) u_dut_small (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .flush_i(flush),
    .mem_valid_i(valid), .mem_rd_wren_i(wren), .mem_rd_addr_i(rd),
    .mem_wb_sel_i(sel), .mem_alu_data_i(alu), .mem_pc_i(pc),
    .mem_imm_i(imm), .mem_ld_data_i(ld), .mem_funct3_i(f3),
`ifdef WB_STAGE_BYPASS_EN
    .rs1_addr_i(rs1_a), .rs2_addr_i(rs2_a), .rs1_raw_i(rs1_raw), .rs2_raw_i(rs2_raw),
    .rs1_byp_o(rs1_byp_s), .rs2_byp_o(rs2_byp_s),
`endif
    .rd_wren_o(rd_wren_s), .rd_addr_o(rd_addr_s), .rd_data_o(rd_data_s),
    .wb_valid_o(wb_valid_s), .instret_o(instret_s)
  );

  // Reference state: the instruction currently in WB and the retire count.
  logic        m_valid, m_wren;
  logic [4:0]  m_rd;
  logic [1:0]  m_sel;
  logic [31:0] m_alu, m_pc, m_imm, m_ld, m_cnt;
  logic [2:0]  m_f3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(logic [31:0] word, logic [1:0] off, logic [2:0] kind);
    logic [31:0] b, h;
    b = (word >> (8 * off)) & 32'hFF;
    h = (word >> (16 * (off / 2))) & 32'hFFFF;
    case (kind)
      3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'b101:  return h;
      default: return word;
    endcase
  endfunction

  function automatic logic exp_write();
    return m_valid && m_wren && (m_rd != 0);
  endfunction

  function automatic logic [31:0] exp_data();
    if (!exp_write()) return 0;
    case (m_sel)
      2'd0:    return m_alu;
      2'd1:    return ref_load(m_ld, m_alu[1:0], m_f3);
      2'd2:    return m_pc + 4;
      default: return m_imm;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_wren = 0; m_rd = 0; m_sel = 0; m_alu = 0;
    m_pc = 0; m_imm = 0; m_ld = 0; m_f3 = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    if (m_valid && !stall) m_cnt = m_cnt + 1;
    if (flush) m_valid = 0;
    else if (!stall) begin
      m_valid = valid; m_wren = wren; m_rd = rd; m_sel = sel; m_alu = alu;
      m_pc = pc; m_imm = imm; m_ld = ld; m_f3 = f3;
    end
  endtask

  task automatic compare();
    check("wb_valid", 32'(wb_valid), 32'(m_valid));
    check("rd_wren", 32'(rd_wren), 32'(exp_write()));
    check("rd_addr", 32'(rd_addr), exp_write() ? 32'(m_rd) : 0);
    check("rd_data", rd_data, exp_data());
    check("instret", instret, m_cnt);
    check("instret_small", 32'(instret_s), m_cnt & 32'h7);
`ifdef WB_STAGE_BYPASS_EN
    check("rs1_byp", rs1_byp, (exp_write() && m_rd == rs1_a) ? exp_data() : rs1_raw);
    check("rs2_byp", rs2_byp, (exp_write() && m_rd == rs2_a) ? exp_data() : rs2_raw);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic issue(input logic v, input logic w, input logic [4:0] r, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] p, input logic [31:0] i,
                       input logic [31:0] l, input logic [2:0] f);
    valid = v; wren = w; rd = r; sel = s; alu = a; pc = p; imm = i; ld = l; f3 = f;
  endtask

  task automatic bubble();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load_test(input logic [2:0] kind, input logic [1:0] off, input logic [31:0] exp, input string tag);
    issue(1, 1, 5'd3, 2'd1, 32'h1000 + 32'(off), 0, 0, 32'h80F0_7F01, kind);
    tick();
    check(tag, rd_data, exp);
  endtask

  initial begin
    logic [31:0] snap_data, snap_cnt;
    rst_n = 0; stall = 0; flush = 0;
    bubble();
`ifdef WB_STAGE_BYPASS_EN
    rs1_a = 0; rs2_a = 0; rs1_raw = 0; rs2_raw = 0;
`endif
    model_reset();
    @(negedge clk);
    compare();
    rst_n = 1;

    // First capture and retire
    issue(1, 1, 5'd5, 2'd0, 32'h1234_5678, 0, 0, 0, 0);
    tick();
    check("first_wren", 32'(rd_wren), 1);
    check("first_addr", 32'(rd_addr), 5);
    check("first_data", rd_data, 32'h1234_5678);
    check("first_cnt0", instret, 0);
    bubble();
    tick();
    check("first_cnt1", instret, 1);

    load_test(3'b000, 2'd3, 32'hFFFF_FF80, "lb_off3");
    load_test(3'b100, 2'd3, 32'h0000_0080, "lbu_off3");
    load_test(3'b001, 2'd2, 32'hFFFF_80F0, "lh_off2");
    load_test(3'b101, 2'd1, 32'h0000_7F01, "lhu_off1");
    load_test(3'b010, 2'd0, 32'h80F0_7F01, "lw");

    // Write to x0 is suppressed but still retires
    issue(1, 1, 5'd0, 2'd0, 32'hDEAD_BEEF, 0, 0, 0, 0);
    tick();
    check("x0_wren", 32'(rd_wren), 0);
    check("x0_data", rd_data, 0);
    snap_cnt = instret;
    bubble();
    tick();
    check("x0_retire", instret, snap_cnt + 1);

    // JAL at top of address space: PC+4 wraps
    issue(1, 1, 5'd1, 2'd2, 0, 32'hFFFF_FFFC, 0, 0, 0);
    tick();
    check("jal_wren", 32'(rd_wren), 1);
    check("jal_wrap", rd_data, 0);

    // Stall freezes outputs and counter
    issue(1, 1, 5'd9, 2'd0, 32'h0000_CAFE, 0, 0, 0, 0);
    tick();
    snap_data = rd_data; snap_cnt = instret;
    issue(1, 1, 5'd10, 2'd3, 0, 0, 32'h5555_0000, 0, 0);
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_data", rd_data, snap_data);
      check("stall_cnt", instret, snap_cnt);
    end
    flush = 1;
    tick();
    check("stall_flush_valid", 32'(wb_valid), 0);
    check("stall_flush_cnt", instret, snap_cnt);
    stall = 0; flush = 0;

`ifdef WB_STAGE_BYPASS_EN
    issue(1, 1, 5'd7, 2'd3, 0, 0, 32'hA5A5_A5A5, 0, 0);
    rs1_a = 7; rs1_raw = 0; rs2_a = 6; rs2_raw = 32'h11;
    tick();
    check("byp_hit", rs1_byp, 32'hA5A5_A5A5);
    check("byp_miss", rs2_byp, 32'h11);
`endif

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      issue($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom),
            2'($urandom), $urandom, $urandom, $urandom, $urandom, 3'($urandom));
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
`ifdef WB_STAGE_BYPASS_EN
      rs1_a = (n % 2 == 0) ? m_rd : 5'($urandom); rs2_a = 5'($urandom);
      rs1_raw = $urandom; rs2_raw = $urandom;
`endif
      tick();
    end

    // Asynchronous reset between clock edges
    stall = 0; flush = 0;
    issue(1, 1, 5'd12, 2'd0, 32'h7777_7777, 0, 0, 0, 0);
    tick();
    #2 rst_n = 0;
    #1;
    model_reset();
    check("arst_valid", 32'(wb_valid), 0);
    check("arst_wren", 32'(rd_wren), 0);
    check("arst_addr", 32'(rd_addr), 0);
    check("arst_data", rd_data, 0);
    check("arst_cnt", instret, 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    check("post_rst_capture", rd_data, 32'h7777_7777);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
